// File: rtl/custom_buff_sched_ctrl.sv
// Step scheduler: walks steps 0..LAST_STEP, issuing buffer read strobes once every
// buffer a step consumes is ready, with stall freeze and a wait-timeout abort.
module custom_buff_sched_ctrl #(
  parameter int LAST_STEP  = 25,
  parameter int WAIT_LIMIT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stall_i,
  output logic [4:0] cnt_o,
  input  logic [3:0] buff_use_i,
  input  logic [3:0] buf_rdy_i,
  output logic [3:0] buf_rd_o,
  output logic       step_valid_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o
);

  localparam int WW = $clog2(WAIT_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, RUN, WAIT, DONE} state_t;

  state_t          state;
  logic [WW-1:0]   wait_cnt;
  logic            blocked;
  logic            issue;
  logic            last_step;

  assign blocked   = |(buff_use_i & ~buf_rdy_i);
  assign last_step = (cnt_o == 5'(LAST_STEP));

  // NOTE: strobes are combinational from the state register so a step issues in the
  // same cycle its buffers become ready; async reset clears state and thus the strobes.
  assign issue        = ((state == RUN) || (state == WAIT)) && !stall_i && !blocked;
  assign step_valid_o = issue;
  assign buf_rd_o     = issue ? buff_use_i : 4'b0000;

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt_o    <= '0;
      wait_cnt <= '0;
      err_o    <= 1'b0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          cnt_o    <= '0;
          wait_cnt <= '0;
          if (start) begin
            state  <= RUN;
            err_o  <= 1'b0;
            busy_o <= 1'b1;
          end
        end
        RUN, WAIT: begin
          if (issue) begin
            wait_cnt <= '0;
            if (last_step) begin
              state  <= DONE;
              busy_o <= 1'b0;
              done_o <= 1'b1;
            end else begin
              cnt_o <= cnt_o + 5'd1;
              state <= RUN;
            end
          end else if (stall_i) begin
            state <= state;
          end else if (state == RUN) begin
            state    <= WAIT;
            wait_cnt <= WW'(1);
          end else if (wait_cnt == WW'(WAIT_LIMIT)) begin
            // Saturated wait: abort the run rather than let the counter wrap.
            err_o  <= 1'b1;
            state  <= DONE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        DONE: begin
          state    <= IDLE;
          cnt_o    <= '0;
          wait_cnt <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_custom_buff_sched_ctrl.sv
// Directed bench for custom_buff_sched_ctrl: a scoreboard queue holds the expected
// (step, strobe) sequence and is drained as the DUT issues steps.
module tb_custom_buff_sched_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stall_i = 1'b0;
  logic [4:0] cnt_o;
  logic [3:0] buff_use_i;
  logic [3:0] buf_rdy_i = 4'hF;
  logic [3:0] buf_rd_o;
  logic       step_valid_o, busy_o, done_o, err_o;

  custom_buff_sched_ctrl #(.LAST_STEP(25), .WAIT_LIMIT(15)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall_i(stall_i), .cnt_o(cnt_o),
    .buff_use_i(buff_use_i), .buf_rdy_i(buf_rdy_i), .buf_rd_o(buf_rd_o),
    .step_valid_o(step_valid_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] cnt;
    logic [3:0] rd;
  } step_t;

  step_t sbq[$];
  int    errors = 0;
  int    checks = 0;
  int    mode = 0;
  int    aux = 0;
  int    dones = 0;
  int    quiet_cyc = 0;
  logic  start_nxt = 1'b0;
  logic  done_seen = 1'b0;
  logic  err_at_done = 1'b0;

  // External buffer-use decoder model; step 5 uses buffer 3 only, step 0 uses none.
  function automatic logic [3:0] dec(input logic [4:0] c);
    if (c == 5'd5) return 4'b1000;
    return c[3:0] ^ {2'b00, c[4], 1'b0};
  endfunction

  assign buff_use_i = dec(cnt_o);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_run(input int first, input int last);
    for (int i = first; i <= last; i++)
      sbq.push_back(step_t'{cnt: 5'(i), rd: dec(5'(i))});
  endtask

  // One cycle: drive inputs at the falling edge, sample just after, DUT acts on next rise.
  task automatic tick();
    bit    quiet;
    bit    expect_issue;
    step_t e;
    quiet = 1'b0;
    expect_issue = 1'b0;
    @(negedge clk);
    start     = start_nxt;
    buf_rdy_i = 4'hF;
    stall_i   = 1'b0;
    case (mode)
      1: if (cnt_o == 5'd5 && busy_o) begin
           if (aux < 4) begin buf_rdy_i = 4'h7; aux++; quiet = 1'b1; end
           else expect_issue = 1'b1;
         end
      2: if (cnt_o >= 5'd5) begin buf_rdy_i = 4'h0; quiet = 1'b1; end
      3: if (cnt_o == 5'd10 && busy_o) begin
           if (aux < 3) begin stall_i = 1'b1; aux++; quiet = 1'b1; end
           else expect_issue = 1'b1;
         end
      default: ;
    endcase
    #2;
    done_seen = done_o;
    if (done_o) begin
      dones++;
      err_at_done = err_o;
    end
    if (quiet) begin
      check("quiet_valid", step_valid_o, 0);
      if (busy_o) quiet_cyc++;
    end
    if (mode == 3 && quiet) check("stall_wait_cnt", dut.wait_cnt, 0);
    if (expect_issue) check("release_issue", step_valid_o, 1);
    if (step_valid_o) begin
      if (sbq.size() == 0) check("unexpected_step", step_valid_o, 0);
      else begin
        e = sbq.pop_front();
        check("step_cnt", cnt_o, e.cnt);
        check("step_rd", buf_rd_o, e.rd);
      end
    end else begin
      check("rd_without_valid", buf_rd_o, 0);
    end
  endtask

  task automatic run_to_done(input int budget);
    done_seen = 1'b0;
    for (int i = 0; i < budget && !done_seen; i++) tick();
    check("run_reaches_done", done_seen, 1);
  endtask

  task automatic start_run();
    start_nxt = 1'b1;
    tick();
    check("idle_not_busy", busy_o, 0);
    start_nxt = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_cnt", cnt_o, 0);
    check("rst_valid", step_valid_o, 0);
    check("rst_rd", buf_rd_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_err", err_o, 0);
    check("rst_wait_cnt", dut.wait_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Nominal full run
    mode = 0; dones = 0;
    push_run(0, 25);
    start_run();
    run_to_done(60);
    check("nom_sb_empty", sbq.size(), 0);
    check("nom_dones", dones, 1);
    check("nom_err", err_at_done, 0);
    tick();
    check("nom_done_one_cycle", done_o, 0);
    check("nom_cnt_back_zero", cnt_o, 0);

    // Buffer 3 not ready for 4 cycles at step 5
    mode = 1; aux = 0; dones = 0;
    push_run(0, 25);
    start_run();
    run_to_done(60);
    check("wait_cycles", aux, 4);
    check("wait_sb_empty", sbq.size(), 0);
    check("wait_err", err_at_done, 0);

    // Timeout: nothing ready from step 5 on
    mode = 2; quiet_cyc = 0; dones = 0;
    push_run(0, 4);
    start_run();
    run_to_done(60);
    check("tmo_sb_empty", sbq.size(), 0);
    check("tmo_stuck_cycles", quiet_cyc, 16);
    check("tmo_err_at_done", err_at_done, 1);
    mode = 0;
    tick(); tick(); tick();
    check("tmo_err_sticky", err_o, 1);
    check("tmo_idle_cnt", cnt_o, 0);
    push_run(0, 25);
    start_nxt = 1'b1;
    tick();
    check("tmo_err_until_accept", err_o, 1);
    start_nxt = 1'b0;
    tick();
    check("tmo_err_cleared", err_o, 0);
    run_to_done(60);
    check("tmo_rerun_sb_empty", sbq.size(), 0);

    // Stall at step 10
    mode = 3; aux = 0;
    push_run(0, 25);
    start_run();
    run_to_done(60);
    check("stall_cycles", aux, 3);
    check("stall_sb_empty", sbq.size(), 0);

    // Reset mid-run at step 12
    mode = 0; dones = 0;
    push_run(0, 12);
    start_run();
    for (int i = 0; i < 40 && cnt_o != 5'd12; i++) tick();
    check("rstmid_reached_12", cnt_o, 12);
    #1 rst_n = 1'b0;
    #1;
    check("rstmid_cnt", cnt_o, 0);
    check("rstmid_valid", step_valid_o, 0);
    check("rstmid_rd", buf_rd_o, 0);
    check("rstmid_busy", busy_o, 0);
    tick(); tick();
    check("rstmid_no_done", dones, 0);
    check("rstmid_sb_empty", sbq.size(), 0);
    rst_n = 1'b1;
    push_run(0, 25);
    start_run();
    run_to_done(60);
    check("rstmid_rerun_sb_empty", sbq.size(), 0);

    // Start held through a run and into DONE
    dones = 0;
    push_run(0, 25);
    start_nxt = 1'b1;
    tick();
    run_to_done(60);
    check("held_first_sb_empty", sbq.size(), 0);
    push_run(0, 25);
    tick();
    check("held_idle_busy", busy_o, 0);
    check("held_idle_cnt", cnt_o, 0);
    start_nxt = 1'b0;
    run_to_done(60);
    check("held_second_sb_empty", sbq.size(), 0);
    check("held_dones", dones, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
